// File: rtl/hbwif_serdes.sv
// HBWIF serial-link framing core: 2*DIVISOR-bit words <-> 2-bit pairs, one frame every DIVISOR cycles.
// Optional HBWIF_SERDES_LOOPBACK_EN adds io_config_loopback, which feeds io_tx_out into the RX path.
module hbwif_serdes #(
   parameter int DIVISOR = 8,
   parameter int NUM_RX = 3,
   localparam int W = 2 * DIVISOR,
   localparam int SELW = (NUM_RX > 1) ? $clog2(NUM_RX) : 1,
   localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1
) (
   input  logic              io_clks,
   input  logic              io_reset_n,
   input  logic [W-1:0]      io_tx_in,
   output logic              io_tx_ready,
   output logic [1:0]        io_tx_out,
   input  logic [2*NUM_RX-1:0] io_rx_in,
   input  logic [SELW-1:0]   io_config_rx_sel,
   input  logic              io_config_rx_edge_sel,
`ifdef HBWIF_SERDES_LOOPBACK_EN
   input  logic              io_config_loopback,
`endif
   output logic [W-1:0]      io_rx_out,
   output logic              io_rx_valid
);

   logic [CW-1:0] cnt;
   logic          last_slot;
   logic [W-1:0]  tsr;
   logic [W-3:0]  rsr;
   logic          last;
   logic [1:0]    lane_p;
   logic [1:0]    p;
   logic [1:0]    q;
   logic [W-1:0]  rx_word;

   assign last_slot   = (cnt == CW'(DIVISOR - 1));
   assign io_tx_ready = last_slot && io_reset_n;
   assign io_tx_out   = tsr[W-1:W-2];

   // Out-of-range selects fall back to lane 0 because no loop iteration matches.
   always_comb begin
      lane_p = io_rx_in[1:0];
      for (int k = 0; k < NUM_RX; k++) begin
         if (io_config_rx_sel == SELW'(k)) begin
            lane_p = io_rx_in[2*k +: 2];
         end
      end
   end

`ifdef HBWIF_SERDES_LOOPBACK_EN
   assign p = io_config_loopback ? io_tx_out : lane_p;
`else
   assign p = lane_p;
`endif

   // Shifted pairing delays the stream by one bit so that a sampler offset by half a pair realigns.
   assign q       = io_config_rx_edge_sel ? {last, p[1]} : p;
   assign rx_word = {rsr, q};

   always_ff @(posedge io_clks) begin
      if (!io_reset_n) begin
         cnt         <= '0;
         tsr         <= '0;
         rsr         <= '0;
         last        <= 1'b0;
         io_rx_out   <= '0;
         io_rx_valid <= 1'b0;
      end else begin
         cnt  <= last_slot ? '0 : cnt + CW'(1);
         tsr  <= last_slot ? io_tx_in : {tsr[W-3:0], 2'b00};
         rsr  <= rx_word[W-3:0];
         last <= p[0];
         io_rx_valid <= last_slot;
         if (last_slot) begin
            io_rx_out <= rx_word;
         end
      end
   end

endmodule

// File: tb/tb_hbwif_serdes.sv
// Directed bench for hbwif_serdes: reset, TX pair order, lane-1 loopback, edge alignment, lane select, mid-frame reset.
module tb_hbwif_serdes;
   localparam int DIVISOR = 8;
   localparam int NUM_RX = 3;
   localparam int W = 2 * DIVISOR;

   logic          io_clks = 1'b0;
   logic          io_reset_n;
   logic [W-1:0]  io_tx_in;
   logic          io_tx_ready;
   logic [1:0]    io_tx_out;
   logic [5:0]    io_rx_in;
   logic [1:0]    io_config_rx_sel;
   logic          io_config_rx_edge_sel;
`ifdef HBWIF_SERDES_LOOPBACK_EN
   logic          io_config_loopback;
`endif
   logic [W-1:0]  io_rx_out;
   logic          io_rx_valid;

   logic          loop_mode;
   logic [1:0]    lane0, lane1, lane2;
   int            nvec = 0;
   int            nfail = 0;

   always #5 io_clks = ~io_clks;

   // External pair loopback onto lane 1 when loop_mode is set.
   assign io_rx_in = {lane2, (loop_mode ? io_tx_out : lane1), lane0};

   hbwif_serdes #(.DIVISOR(DIVISOR), .NUM_RX(NUM_RX)) dut (
      .io_clks               (io_clks),
      .io_reset_n            (io_reset_n),
      .io_tx_in              (io_tx_in),
      .io_tx_ready           (io_tx_ready),
      .io_tx_out             (io_tx_out),
      .io_rx_in              (io_rx_in),
      .io_config_rx_sel      (io_config_rx_sel),
      .io_config_rx_edge_sel (io_config_rx_edge_sel),
`ifdef HBWIF_SERDES_LOOPBACK_EN
      .io_config_loopback    (io_config_loopback),
`endif
      .io_rx_out             (io_rx_out),
      .io_rx_valid           (io_rx_valid)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for the load slot on a falling edge.
   task automatic wait_ready();
      int n = 0;
      @(negedge io_clks);
      while (!io_tx_ready && n < 3 * DIVISOR) begin
         @(negedge io_clks);
         n++;
      end
      if (!io_tx_ready) check("ready_timeout", {15'b0, io_tx_ready}, 16'h0001);
   endtask

   // Loads one word; returns #1 after the load edge, where the previous frame's word is on io_rx_out.
   task automatic frame(input logic [W-1:0] word, input bit chk, input logic [W-1:0] exp, input string tag);
      wait_ready();
      io_tx_in = word;
      @(posedge io_clks);
      #1;
      if (chk) begin
         check({tag, "_valid"}, {15'b0, io_rx_valid}, 16'h0001);
         check(tag, io_rx_out, exp);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [1:0] exp_pairs [8];
      logic [W-1:0] words [5];
      int n;
      exp_pairs = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd3};

      io_reset_n = 1'b0;
      io_tx_in = 16'hFFFF;
      io_config_rx_sel = 2'd1;
      io_config_rx_edge_sel = 1'b0;
`ifdef HBWIF_SERDES_LOOPBACK_EN
      io_config_loopback = 1'b0;
`endif
      loop_mode = 1'b0;
      lane0 = 2'b00; lane1 = 2'b00; lane2 = 2'b00;

      // 1: reset held three cycles
      repeat (3) @(posedge io_clks);
      #1;
      check("rst_tx_out", {14'b0, io_tx_out}, 16'h0000);
      check("rst_rx_out", io_rx_out, 16'h0000);
      check("rst_rx_valid", {15'b0, io_rx_valid}, 16'h0000);
      check("rst_tx_ready", {15'b0, io_tx_ready}, 16'h0000);
      @(negedge io_clks);
      io_reset_n = 1'b1;
      n = 0;
      do begin
         @(posedge io_clks);
         #1;
         n++;
      end while (!io_tx_ready && n < 3 * DIVISOR);
      check("ready_after_release", W'(n), 16'd7);
      check("tx_out_idle", {14'b0, io_tx_out}, 16'h0000);

      // 2: TX pair order
      frame(16'hA5C3, 1'b0, 16'h0000, "none");
      for (int i = 0; i < 8; i++) begin
         check($sformatf("tx_pair%0d", i), {14'b0, io_tx_out}, {14'b0, exp_pairs[i]});
         check($sformatf("tx_ready%0d", i), {15'b0, io_tx_ready}, {15'b0, (i == 7)});
         if (i < 7) begin
            @(posedge io_clks);
            #1;
         end
      end

      // 3: loopback through lane 1, direct pairing
      loop_mode = 1'b1;
      io_config_rx_sel = 2'd1;
      words = '{16'h1000, 16'h1101, 16'h1202, 16'h1303, 16'h1404};
      frame(words[0], 1'b0, 16'h0000, "none");
      for (int k = 1; k < 5; k++) begin
         frame(words[k], 1'b1, words[k-1], $sformatf("loop_word%0d", k - 1));
      end
      @(posedge io_clks);
      #1;
      check("rx_valid_low_slot1", {15'b0, io_rx_valid}, 16'h0000);
      check("rx_out_held", io_rx_out, words[3]);

      // 4: one-bit shifted pairing; the last bit of each word carries into the next
      io_config_rx_edge_sel = 1'b1;
      frame(16'h0000, 1'b0, 16'h0000, "none");
      frame(16'h0001, 1'b0, 16'h0000, "none");
      frame(16'h8000, 1'b1, 16'h0000, "edge_w0001");
      frame(16'h0003, 1'b1, 16'hC000, "edge_w8000");
      frame(16'h0000, 1'b1, 16'h0001, "edge_w0003");
      frame(16'h0000, 1'b1, 16'h8000, "edge_w0000");

      // 5: lane isolation and out-of-range select
      loop_mode = 1'b0;
      io_config_rx_edge_sel = 1'b0;
      lane0 = 2'b11; lane1 = 2'b00; lane2 = 2'b11;
      frame(16'h0000, 1'b0, 16'h0000, "none");
      frame(16'h0000, 1'b1, 16'h0000, "lane1_iso");
      io_config_rx_sel = 2'd3;
      frame(16'h0000, 1'b0, 16'h0000, "none");
      frame(16'h0000, 1'b1, 16'hFFFF, "sel3_lane0");
      lane2 = 2'b00;
      io_config_rx_sel = 2'd2;
      frame(16'h0000, 1'b0, 16'h0000, "none");
      frame(16'h0000, 1'b1, 16'h0000, "lane2_iso");
      io_config_rx_sel = 2'd3;
      frame(16'h0000, 1'b0, 16'h0000, "none");
      frame(16'hF00F, 1'b1, 16'hFFFF, "sel3_not_lane2");

      // mid-frame reset clears everything and no partial word follows
      @(negedge io_clks);
      io_reset_n = 1'b0;
      @(posedge io_clks);
      #1;
      check("midrst_tx_out", {14'b0, io_tx_out}, 16'h0000);
      check("midrst_rx_out", io_rx_out, 16'h0000);
      check("midrst_rx_valid", {15'b0, io_rx_valid}, 16'h0000);
      @(negedge io_clks);
      io_reset_n = 1'b1;
      @(posedge io_clks);
      #1;
      check("postrst_tx_out", {14'b0, io_tx_out}, 16'h0000);

`ifdef HBWIF_SERDES_LOOPBACK_EN
      // 6: internal loopback overrides the lanes
      lane0 = 2'b11; lane1 = 2'b11; lane2 = 2'b11;
      io_config_rx_sel = 2'd1;
      io_config_loopback = 1'b1;
      frame(16'h1357, 1'b0, 16'h0000, "none");
      frame(16'h2468, 1'b1, 16'h1357, "int_loop0");
      frame(16'h0000, 1'b1, 16'h2468, "int_loop1");
      io_config_loopback = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
